// File: rtl/we_bank_pkg.sv
// Shared definitions for the write-enabled register bank.
// Scan state encoding, anode polarity and address width helper.
package we_bank_pkg;

    // Address width for a given channel count, never narrower than 1 bit.
    function automatic int we_bank_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Prescaler width for a given slot length, never narrower than 1 bit.
    function automatic int we_bank_pw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Widest anode vector the bank supports; tops slice what they need.
    localparam int ANODE_MAX = 64;

    // Active-low anodes: all ones means every digit is dark.
    localparam logic [ANODE_MAX-1:0] ANODE_OFF = '1;

    // Scan sequencer states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/we_register_bank_scan_timer.sv
// Scan sequencer: prescaler plus slot counter for the register bank.
// slot_nxt exposes the next slot so the top can register its anodes.
module scan_timer
    import we_bank_pkg::*;
#(
    parameter int PRESC   = 16,
    parameter int CANALES = 4,
    localparam int AW     = we_bank_aw(CANALES),
    localparam int PW     = we_bank_pw(PRESC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Scan_EN,
    output logic [AW-1:0] slot,
    output logic [AW-1:0] slot_nxt,
    output logic          Slot_Tick
);

    localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);
    localparam logic [AW-1:0] SLAST = AW'(CANALES - 1);

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic          tick_nxt;

    logic          go_idle;
    logic          start;
    logic          wrap;
    logic          count;

    assign go_idle = !Scan_EN;
    assign start   = Scan_EN && (state == ST_IDLE);
    assign wrap    = Scan_EN && (state == ST_RUN) && (presc == PLAST);
    assign count   = Scan_EN && (state == ST_RUN) && (presc != PLAST);

    // Next-state decode; the four conditions are mutually exclusive.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        slot_nxt  = slot;
        tick_nxt  = 1'b0;
        unique case (1'b1)
            go_idle: begin
                state_nxt = ST_IDLE;
                presc_nxt = '0;
                slot_nxt  = '0;
            end
            start: begin
                // First slot starts fresh and carries no tick.
                state_nxt = ST_RUN;
                presc_nxt = '0;
                slot_nxt  = '0;
            end
            wrap: begin
                presc_nxt = '0;
                slot_nxt  = (slot == SLAST) ? '0 : slot + AW'(1);
                tick_nxt  = 1'b1;
            end
            count: begin
                presc_nxt = presc + PW'(1);
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    // Sequencer registers; tick is registered so it aligns with slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            presc     <= '0;
            slot      <= '0;
            Slot_Tick <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            slot      <= slot_nxt;
            Slot_Tick <= tick_nxt;
        end
    end

endmodule

// File: rtl/we_register_bank.sv
// Multi-channel write-enabled register bank with display scan output.
// Optional readback port enabled by defining WE_BANK_READBACK_EN.
module we_register_bank
    import we_bank_pkg::*;
#(
    parameter int ANCHO   = 4,
    parameter int CANALES = 4,
    parameter int PRESC   = 16,
    localparam int W      = 2 ** ANCHO,
    localparam int AW     = we_bank_aw(CANALES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       Data,
    input  logic [AW-1:0]      Addr,
    input  logic               EN,
    input  logic               Clear,
    input  logic               Scan_EN,
    output logic [CANALES-1:0] Anode,
    output logic [AW-1:0]      Scan_Sel,
    output logic [W-1:0]       Scan_Data,
    output logic               Slot_Tick
`ifdef WE_BANK_READBACK_EN
    ,
    input  logic [AW-1:0]      Rd_Addr,
    output logic [W-1:0]       Rd_Data
`endif
);

    localparam logic [CANALES-1:0] OFF = ANODE_OFF[CANALES-1:0];
    localparam logic [CANALES-1:0] ONE = CANALES'(1);

    logic [W-1:0]  bank [CANALES];
    logic [AW-1:0] slot_nxt;
    logic          wr_ok;

    assign wr_ok = EN && (32'(Addr) < CANALES);

    scan_timer #(
        .PRESC   (PRESC),
        .CANALES (CANALES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .Scan_EN   (Scan_EN),
        .slot      (Scan_Sel),
        .slot_nxt  (slot_nxt),
        .Slot_Tick (Slot_Tick)
    );

    // Bank storage; Clear wins over a write on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CANALES; i++) begin
                bank[i] <= '0;
            end
        end else if (Clear) begin
            for (int i = 0; i < CANALES; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_ok) begin
            bank[Addr] <= Data;
        end
    end

    // Anodes decoded from the next slot so they flip with Scan_Sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Anode <= OFF;
        end else if (Scan_EN) begin
            Anode <= ~(ONE << slot_nxt);
        end else begin
            Anode <= OFF;
        end
    end

    assign Scan_Data = bank[Scan_Sel];

`ifdef WE_BANK_READBACK_EN
    // Registered readback; a same-edge write is seen one read later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Rd_Data <= '0;
        end else if (32'(Rd_Addr) < CANALES) begin
            Rd_Data <= bank[Rd_Addr];
        end else begin
            Rd_Data <= '0;
        end
    end
`else
    // Readback port and its register are not built.
`endif

endmodule

// File: tb/tb_we_register_bank.sv
// Directed bench for we_register_bank with ANCHO=4, CANALES=4, PRESC=4.
// Table of per-cycle vectors plus hand-written corner sequences.
module tb_we_register_bank;

    localparam int ANCHO   = 4;
    localparam int CANALES = 4;
    localparam int PRESC   = 4;

    logic       clk;
    logic       rst;
    logic [3:0] Data;
    logic [1:0] Addr;
    logic       EN;
    logic       Clear;
    logic       Scan_EN;
    logic [3:0] Anode;
    logic [1:0] Scan_Sel;
    logic [3:0] Scan_Data;
    logic       Slot_Tick;
`ifdef WE_BANK_READBACK_EN
    logic [1:0] Rd_Addr;
    logic [3:0] Rd_Data;
`endif

    int tests;
    int fails;

    we_register_bank #(
        .ANCHO   (ANCHO),
        .CANALES (CANALES),
        .PRESC   (PRESC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Data      (Data),
        .Addr      (Addr),
        .EN        (EN),
        .Clear     (Clear),
        .Scan_EN   (Scan_EN),
        .Anode     (Anode),
        .Scan_Sel  (Scan_Sel),
        .Scan_Data (Scan_Data),
        .Slot_Tick (Slot_Tick)
`ifdef WE_BANK_READBACK_EN
        ,
        .Rd_Addr   (Rd_Addr),
        .Rd_Data   (Rd_Data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic [1:0] addr;
        logic [3:0] data;
        logic       scan;
        logic [3:0] anode;
        logic [1:0] sel;
        logic [3:0] sdata;
        logic       tick;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] an,
                           input logic [1:0] sel, input logic [3:0] sd,
                           input logic tk);
        chk({name, ".anode"}, 32'(Anode), 32'(an));
        chk({name, ".sel"}, 32'(Scan_Sel), 32'(sel));
        chk({name, ".sdata"}, 32'(Scan_Data), 32'(sd));
        chk({name, ".tick"}, 32'(Slot_Tick), 32'(tk));
    endtask

    function automatic vec_t mk(input logic en, input logic clr,
                                input logic [1:0] addr,
                                input logic [3:0] data, input logic scan,
                                input logic [3:0] an, input logic [1:0] sel,
                                input logic [3:0] sd, input logic tk);
        vec_t v;
        v.en = en; v.clr = clr; v.addr = addr; v.data = data;
        v.scan = scan; v.anode = an; v.sel = sel; v.sdata = sd;
        v.tick = tk;
        return v;
    endfunction

    logic [3:0] an_tab [4];
    logic [3:0] val_tab [4];

    initial begin
        tests = 0;
        fails = 0;
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        val_tab = '{4'hA, 4'hB, 4'hC, 4'hD};

        // Writes while idle: slot 0 shows channel 0 once written.
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b1, 1'b0, 2'(i), val_tab[i], 1'b0,
                             4'b1111, 2'd0, 4'hA, 1'b0));
        // Full scan plus the wrap back into slot 0.
        for (int s = 0; s < 5; s++)
            for (int p = 0; p < 4; p++)
                if (s < 4 || p == 0)
                    tbl.push_back(mk(1'b0, 1'b0, 2'd0, 4'h0, 1'b1,
                                     an_tab[s % 4], 2'(s % 4),
                                     val_tab[s % 4],
                                     (p == 0) && (s != 0)));

        rst = 1'b1; Data = '0; Addr = '0; EN = 1'b0;
        Clear = 1'b0; Scan_EN = 1'b0;
`ifdef WE_BANK_READBACK_EN
        Rd_Addr = '0;
`endif
        step();
        step();
        chk_out("reset", 4'b1111, 2'd0, 4'h0, 1'b0);
        rst = 1'b0;
        step();
        chk_out("post_reset", 4'b1111, 2'd0, 4'h0, 1'b0);

        foreach (tbl[i]) begin
            EN = tbl[i].en; Clear = tbl[i].clr; Addr = tbl[i].addr;
            Data = tbl[i].data; Scan_EN = tbl[i].scan;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].anode, tbl[i].sel,
                    tbl[i].sdata, tbl[i].tick);
        end

        // Mid-slot write to the displayed channel; slot stays 4 cycles.
        EN = 1'b1; Addr = 2'd0; Data = 4'h7;
        step();
        chk_out("midwr", 4'b1110, 2'd0, 4'h7, 1'b0);
        EN = 1'b0;
        step();
        chk_out("midwr_p2", 4'b1110, 2'd0, 4'h7, 1'b0);
        step();
        chk_out("midwr_p3", 4'b1110, 2'd0, 4'h7, 1'b0);
        step();
        chk_out("midwr_adv", 4'b1101, 2'd1, 4'hB, 1'b1);

        // Drop scan in slot 2, then restart with a full slot 0.
        step(); step(); step(); step();
        chk_out("slot2", 4'b1011, 2'd2, 4'hC, 1'b1);
        step();
        Scan_EN = 1'b0;
        step();
        chk_out("drop", 4'b1111, 2'd0, 4'h7, 1'b0);
        Scan_EN = 1'b1;
        step();
        chk_out("restart", 4'b1110, 2'd0, 4'h7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("restart_p%0d", i + 1), 4'b1110, 2'd0,
                    4'h7, 1'b0);
        end
        step();
        chk_out("restart_adv", 4'b1101, 2'd1, 4'hB, 1'b1);

        // Clear beats a same-edge write; every channel reads back 0.
        EN = 1'b1; Clear = 1'b1; Addr = 2'd2; Data = 4'h5;
        step();
        EN = 1'b0; Clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("clear_c%0d", i), 32'(Scan_Data), 32'h0);
            step();
        end

        // Async reset mid-slot 3 with nonzero channels.
        for (int i = 0; i < 4; i++) begin
            EN = 1'b1; Addr = 2'(i); Data = 4'(i + 1);
            step();
        end
        EN = 1'b0;
        for (int i = 0; i < 40 && Scan_Sel != 2'd3; i++) step();
        chk("reach_slot3", 32'(Scan_Sel), 32'd3);
        chk("slot3_data", 32'(Scan_Data), 32'h4);
        step();
        #3;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 4'b1111, 2'd0, 4'h0, 1'b0);

        // No write lands while reset is held.
        EN = 1'b1; Addr = 2'd0; Data = 4'h3; Scan_EN = 1'b0;
        step();
        step();
        EN = 1'b0;
        rst = 1'b0;
        step();
        chk_out("rst_nowrite", 4'b1111, 2'd0, 4'h0, 1'b0);

`ifdef WE_BANK_READBACK_EN
        // Readback sees the old value on a same-edge write.
        EN = 1'b1; Addr = 2'd1; Data = 4'h6;
        step();
        Rd_Addr = 2'd1; Data = 4'h9;
        step();
        chk("rd_old", 32'(Rd_Data), 32'h6);
        EN = 1'b0;
        step();
        chk("rd_new", 32'(Rd_Data), 32'h9);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
